// File: rtl/pc_adder.sv
// -----------------------------------------------------------------------------
// pc_adder -- program-counter incrementer for the RV32 fetch stage.
//
// Produces pc_in + INC combinationally so the next-PC mux sees it in the same
// cycle. It also keeps a registered copy of the sum and the carry for the
// hazard/debug logic, and counts wrap events with a saturating counter.
//
// Parameters:
//   XLEN   datapath width in bits
//   INC    increment constant, unsigned, less than 2^XLEN
//   CNT_W  width of the wrap-event counter
//
// Ports:
//   clk         in   1      system clock, rising-edge active
//   rst_n       in   1      asynchronous, active-low reset
//   pc_in       in   XLEN   current program counter
//   en          in   1      advance enable for the registered outputs
//   pc_out      out  XLEN   pc_in + INC, modulo 2^XLEN (combinational)
//   carry_out   out  1      carry out of the pc_out addition (combinational)
//   misaligned  out  1      pc_in[1:0] != 0 (combinational, report only)
//   pc_out_q    out  XLEN   registered pc_out
//   wrap_q      out  1      registered carry_out
//   wrap_cnt    out  CNT_W  saturating count of wrap events
// -----------------------------------------------------------------------------
module pc_adder #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned INC   = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             en,
  output logic [XLEN-1:0]  pc_out,
  output logic             carry_out,
  output logic             misaligned,
  output logic [XLEN-1:0]  pc_out_q,
  output logic             wrap_q,
  output logic [CNT_W-1:0] wrap_cnt
);

  // The addition is done one bit wider so the carry falls out as the MSB.
  localparam logic [XLEN:0] INC_EXT = (XLEN+1)'(INC);

  logic [XLEN:0]    sum;
  logic [XLEN-1:0]  pc_out_d;
  logic             wrap_d;
  logic [CNT_W-1:0] wrap_cnt_d;
  logic [XLEN-1:0]  pc_out_reg_q;
  logic             wrap_reg_q;
  logic [CNT_W-1:0] wrap_cnt_q;
  logic             cnt_full;

  // ---------------------------------------------------------------------------
  // Combinational sum path: independent of clk, en and reset.
  // ---------------------------------------------------------------------------
  assign sum        = {1'b0, pc_in} + INC_EXT;
  assign pc_out     = sum[XLEN-1:0];
  assign carry_out  = sum[XLEN];
  // Low bits are only reported; the adder sees pc_in unmasked.
  assign misaligned = |pc_in[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic for the status registers.
  // ---------------------------------------------------------------------------
  assign cnt_full = &wrap_cnt_q;

  always_comb begin
    // NOTE: every signal gets a hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    pc_out_d   = pc_out_reg_q;
    wrap_d     = wrap_reg_q;
    wrap_cnt_d = wrap_cnt_q;
    if (en) begin
      pc_out_d = pc_out;
      wrap_d   = carry_out;
      // Saturate instead of rolling over so a long run of wraps is never
      // mistaken for a small count.
      if (carry_out && !cnt_full) begin
        wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: the reset branch is asynchronous, so the registers clear the
  // moment rst_n falls and cannot capture an X pc_in while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out_reg_q <= '0;
      wrap_reg_q   <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      pc_out_reg_q <= pc_out_d;
      wrap_reg_q   <= wrap_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign pc_out_q = pc_out_reg_q;
  assign wrap_q   = wrap_reg_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_pc_adder.sv
// -----------------------------------------------------------------------------
// tb_pc_adder -- self-checking bench for pc_adder.
//
// Two instances share the stimulus: u_dut uses the default CNT_W=16, and
// u_sat uses CNT_W=2 so counter saturation is reachable in a few wraps.
// A behavioural model tracks the expected outputs with plain integer
// arithmetic. One process compares every output against it on each falling
// clock edge, and the directed sequence adds hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_pc_adder;

  localparam int XLEN = 32;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic            en    = 1'b0;

  logic [XLEN-1:0] pc_out, pc_out_q;
  logic            carry_out, misaligned, wrap_q;
  logic [15:0]     wrap_cnt;

  logic [XLEN-1:0] s_pc_out, s_pc_out_q;
  logic            s_carry_out, s_misaligned, s_wrap_q;
  logic [1:0]      s_wrap_cnt;

  int total = 0;
  int bad   = 0;

  // Model state.
  longint unsigned m_pc_q  = 0;
  int              m_wrap  = 0;
  int              m_cnt   = 0;
  int              m_cnt2  = 0;

  pc_adder #(.XLEN(32), .INC(4), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .en         (en),
    .pc_out     (pc_out),
    .carry_out  (carry_out),
    .misaligned (misaligned),
    .pc_out_q   (pc_out_q),
    .wrap_q     (wrap_q),
    .wrap_cnt   (wrap_cnt)
  );

  pc_adder #(.XLEN(32), .INC(4), .CNT_W(2)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .en         (en),
    .pc_out     (s_pc_out),
    .carry_out  (s_carry_out),
    .misaligned (s_misaligned),
    .pc_out_q   (s_pc_out_q),
    .wrap_q     (s_wrap_q),
    .wrap_cnt   (s_wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --- behavioural model -----------------------------------------------------
  function automatic longint unsigned exp_sum(input logic [XLEN-1:0] pc);
    return longint'(pc) + 64'd4;            // full sum, carry in bit 32
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc_q = 0;
      m_wrap = 0;
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (en) begin
      m_pc_q = exp_sum(pc_in) % 64'h1_0000_0000;
      m_wrap = (exp_sum(pc_in) >= 64'h1_0000_0000) ? 1 : 0;
      if (m_wrap == 1) begin
        if (m_cnt  < 65535) m_cnt  = m_cnt + 1;
        if (m_cnt2 < 3)     m_cnt2 = m_cnt2 + 1;
      end
    end
  end

  // --- per-cycle compare -----------------------------------------------------
  always @(negedge clk) begin
    longint unsigned s;
    s = exp_sum(pc_in);
    check("cyc pc_out",     64'(pc_out),       s % 64'h1_0000_0000);
    check("cyc carry_out",  64'(carry_out),    64'(s >> 32));
    check("cyc misaligned", 64'(misaligned),   64'((pc_in % 4) != 0));
    check("cyc pc_out_q",   64'(pc_out_q),     m_pc_q);
    check("cyc wrap_q",     64'(wrap_q),       64'(m_wrap));
    check("cyc wrap_cnt",   64'(wrap_cnt),     64'(m_cnt));
    check("cyc s_pc_out_q", 64'(s_pc_out_q),   m_pc_q);
    check("cyc s_wrap_cnt", 64'(s_wrap_cnt),   64'(m_cnt2));
  end

  // --- directed stimulus -----------------------------------------------------
  task automatic drive(input logic [XLEN-1:0] pc, input logic e);
    @(negedge clk);
    #1;
    pc_in = pc;
    en    = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held: combinational path still works, registers stay clear.
    #1;
    check("rst pc_out 0",      64'(pc_out),     64'h4);
    check("rst carry 0",       64'(carry_out),  64'h0);
    check("rst misaligned 0",  64'(misaligned), 64'h0);
    check("rst pc_out_q",      64'(pc_out_q),   64'h0);
    check("rst wrap_cnt",      64'(wrap_cnt),   64'h0);
    pc_in = 32'h0000_1000;
    #1;
    check("rst pc_out 1000",   64'(pc_out),     64'h1004);
    check("rst carry 1000",    64'(carry_out),  64'h0);
    drive(32'hFFFF_FFFC, 1'b1);
    tick();
    check("rst wrap pc_out",   64'(pc_out),     64'h0);
    check("rst wrap carry",    64'(carry_out),  64'h1);
    check("rst hold pc_out_q", 64'(pc_out_q),   64'h0);
    check("rst hold wrap_cnt", 64'(wrap_cnt),   64'h0);

    // Release reset away from a clock edge; first wrap event.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("wrap1 wrap_q",      64'(wrap_q),     64'h1);
    check("wrap1 wrap_cnt",    64'(wrap_cnt),   64'h1);
    check("wrap1 pc_out_q",    64'(pc_out_q),   64'h0);

    drive(32'h0000_1000, 1'b1);
    tick();
    check("1000 pc_out_q",     64'(pc_out_q),   64'h1004);
    check("1000 wrap_q",       64'(wrap_q),     64'h0);
    check("1000 wrap_cnt",     64'(wrap_cnt),   64'h1);

    // Enable low: three edges hold the previous value.
    drive(32'h0000_0008, 1'b1);
    tick();
    drive(32'h0000_0010, 1'b0);
    tick();
    tick();
    tick();
    check("en0 pc_out_q hold", 64'(pc_out_q),   64'hC);
    drive(32'h0000_0010, 1'b1);
    tick();
    check("en1 pc_out_q",      64'(pc_out_q),   64'h14);

    // Misalignment reporting.
    drive(32'h0000_0002, 1'b0);
    #1;
    check("mis pc_out",        64'(pc_out),     64'h6);
    check("mis flag",          64'(misaligned), 64'h1);
    drive(32'hFFFF_FFFF, 1'b0);
    #1;
    check("ffff pc_out",       64'(pc_out),     64'h3);
    check("ffff carry",        64'(carry_out),  64'h1);
    check("ffff misaligned",   64'(misaligned), 64'h1);

    // Four more wraps (five in total), with a disabled edge in between.
    drive(32'hFFFF_FFFC, 1'b1);
    tick();
    tick();
    drive(32'hFFFF_FFFC, 1'b0);
    tick();
    check("wrap en0 cnt hold", 64'(wrap_cnt),   64'h3);
    drive(32'hFFFF_FFFD, 1'b1);
    tick();
    tick();
    check("wrap5 wrap_cnt",    64'(wrap_cnt),   64'h5);
    check("wrap5 sat cnt",     64'(s_wrap_cnt), 64'h3);
    check("wrap5 pc_out_q",    64'(pc_out_q),   64'h1);

    // Reset asserted mid-cycle: registers clear without a clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst pc_out_q",   64'(pc_out_q),   64'h0);
    check("midrst wrap_q",     64'(wrap_q),     64'h0);
    check("midrst wrap_cnt",   64'(wrap_cnt),   64'h0);
    check("midrst sat cnt",    64'(s_wrap_cnt), 64'h0);
    pc_in = 32'h0000_0020;
    #1;
    check("midrst pc_out",     64'(pc_out),     64'h24);
    tick();
    check("midrst still 0",    64'(pc_out_q),   64'h0);

    // Release again and run a final enabled cycle.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(32'h0000_0100, 1'b1);
    tick();
    check("post pc_out_q",     64'(pc_out_q),   64'h104);
    check("post wrap_cnt",     64'(wrap_cnt),   64'h0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-length guard so the bench always terminates.
  initial begin
    #20000;
    bad++;
    $display("FAIL timeout: got no finish expected finish by 20000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
